// File: rtl/chip_rst_seq_if.sv
// ============================================================================
// Module      : chip_rst_seq_if
// Description : Host/chip handshake bundle for the chip reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface chip_rst_seq_if;
    logic       req;
    logic       chip_ready;
    logic       chip_rst_n;
    logic       busy;
    logic       done;
    logic       timeout_err;
    logic [7:0] rst_count;

    // master = platform controller / chip model, slave = sequencer
    modport master (
        output req, chip_ready,
        input  chip_rst_n, busy, done, timeout_err, rst_count
    );

    modport slave (
        input  req, chip_ready,
        output chip_rst_n, busy, done, timeout_err, rst_count
    );
endinterface

`default_nettype wire

// File: rtl/chip_rst_seq.sv
// ============================================================================
// Module      : chip_rst_seq
// Description : Chip reset sequencer: hold chip_rst_n low, release, await ready.
//               Optional CHIP_RST_READY_SYNC_EN adds a 2-flop chip_ready sync.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chip_rst_seq #(
    parameter int ASSERT_CYCLES = 204,
    parameter int WAIT_MAX      = 1024,
    parameter int CNT_W         = 16
) (
    input  wire            clk,
    input  wire            rst,
    chip_rst_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_WAIT   = 2'd1,
        ST_READY  = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_ASSERT_LAST = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_WAIT_LAST   = CNT_W'(WAIT_MAX - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               chip_rst_n_q, chip_rst_n_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               timeout_err_q, timeout_err_d;
    logic [7:0]         rst_count_q, rst_count_d;
    logic               ready_eff;

`ifdef CHIP_RST_READY_SYNC_EN
    logic [1:0] ready_sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_sync_q <= 2'b00;
        end else begin
            ready_sync_q <= {ready_sync_q[0], bus.chip_ready};
        end
    end

    assign ready_eff = ready_sync_q[1];
`else
    assign ready_eff = bus.chip_ready;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_ASSERT;
            cnt_q         <= '0;
            chip_rst_n_q  <= 1'b0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            rst_count_q   <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            chip_rst_n_q  <= chip_rst_n_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
            rst_count_q   <= rst_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        chip_rst_n_d  = chip_rst_n_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        timeout_err_d = timeout_err_q;
        rst_count_d   = rst_count_q;

        unique case (state_q)
            ST_ASSERT: begin
                chip_rst_n_d = 1'b0;
                busy_d       = 1'b1;
                if (bus.req) begin
                    cnt_d = '0;
                end else if (cnt_q == c_ASSERT_LAST) begin
                    state_d      = ST_WAIT;
                    cnt_d        = '0;
                    chip_rst_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                // req beats ready, ready beats timeout
                if (bus.req) begin
                    state_d      = ST_ASSERT;
                    cnt_d        = '0;
                    chip_rst_n_d = 1'b0;
                    busy_d       = 1'b1;
                end else if (ready_eff) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    if (rst_count_q != 8'hFF) begin
                        rst_count_d = rst_count_q + 8'd1;
                    end
                end else if (cnt_q == c_WAIT_LAST) begin
                    state_d       = ST_ERR;
                    cnt_d         = '0;
                    timeout_err_d = 1'b1;
                    busy_d        = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_READY, ST_ERR: begin
                cnt_d        = '0;
                chip_rst_n_d = 1'b1;
                busy_d       = 1'b0;
                if (bus.req) begin
                    state_d       = ST_ASSERT;
                    chip_rst_n_d  = 1'b0;
                    busy_d        = 1'b1;
                    timeout_err_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_ASSERT;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.chip_rst_n  = chip_rst_n_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.rst_count   = rst_count_q;

endmodule

`default_nettype wire

// File: tb/tb_chip_rst_seq.sv
// ============================================================================
// Module      : tb_chip_rst_seq
// Description : Directed self-checking bench for chip_rst_seq (default build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chip_rst_seq;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    chip_rst_seq_if bus ();

    chip_rst_seq #(
        .ASSERT_CYCLES (204),
        .WAIT_MAX      (1024),
        .CNT_W         (16)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges; inputs are driven and outputs sampled 1ns later.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reset held 3 edges; the next rising edge afterwards is edge 1.
    task automatic apply_reset(input logic ready);
        rst            = 1'b1;
        bus.req        = 1'b0;
        bus.chip_ready = ready;
        step(3);
        rst = 1'b0;
    endtask

    // From READY: one-edge req pulse then 204 ASSERT edges plus 1 WAIT edge.
    task automatic run_seq();
        bus.req = 1'b1;
        step(1);
        bus.req = 1'b0;
        step(205);
    endtask

    task automatic test_reset();
        apply_reset(1'b0);
        chk("reset_chip_rst_n", {7'd0, bus.chip_rst_n}, 8'd0);
        chk("reset_busy",       {7'd0, bus.busy},       8'd1);
        chk("reset_done",       {7'd0, bus.done},       8'd0);
        chk("reset_timeout",    {7'd0, bus.timeout_err}, 8'd0);
        chk("reset_count",      bus.rst_count,          8'd0);
    endtask

    task automatic test_power_on();
        apply_reset(1'b1);
        step(203);
        chk("pon_low_at_203",   {7'd0, bus.chip_rst_n}, 8'd0);
        chk("pon_done_early",   {7'd0, bus.done},       8'd0);
        step(1);
        chk("pon_high_at_204",  {7'd0, bus.chip_rst_n}, 8'd1);
        chk("pon_busy_wait",    {7'd0, bus.busy},       8'd1);
        step(1);
        chk("pon_done_205",     {7'd0, bus.done},       8'd1);
        chk("pon_busy_clear",   {7'd0, bus.busy},       8'd0);
        chk("pon_count_1",      bus.rst_count,          8'd1);
        step(1);
        chk("pon_done_1cyc",    {7'd0, bus.done},       8'd0);
        chk("pon_stay_high",    {7'd0, bus.chip_rst_n}, 8'd1);
    endtask

    task automatic test_timeout();
        apply_reset(1'b0);
        step(204);
        chk("to_release",       {7'd0, bus.chip_rst_n}, 8'd1);
        step(1023);
        chk("to_not_yet",       {7'd0, bus.timeout_err}, 8'd0);
        chk("to_busy_still",    {7'd0, bus.busy},       8'd1);
        step(1);
        chk("to_err_1024",      {7'd0, bus.timeout_err}, 8'd1);
        chk("to_busy_clear",    {7'd0, bus.busy},       8'd0);
        chk("to_no_done",       {7'd0, bus.done},       8'd0);
        step(5);
        chk("to_sticky",        {7'd0, bus.timeout_err}, 8'd1);
        bus.req = 1'b1;
        step(1);
        bus.req = 1'b0;
        chk("to_req_clear",     {7'd0, bus.timeout_err}, 8'd0);
        chk("to_req_rst_low",   {7'd0, bus.chip_rst_n}, 8'd0);
        chk("to_req_busy",      {7'd0, bus.busy},       8'd1);
    endtask

    task automatic test_req_restart();
        apply_reset(1'b0);
        step(99);
        bus.req = 1'b1;
        step(1);
        bus.req = 1'b0;
        step(203);
        chk("rr_low_at_303",    {7'd0, bus.chip_rst_n}, 8'd0);
        step(1);
        chk("rr_high_at_304",   {7'd0, bus.chip_rst_n}, 8'd1);
    endtask

    // Continues from test_req_restart: sequencer sits in WAIT with chip_ready low.
    task automatic test_req_vs_ready();
        bus.req        = 1'b1;
        bus.chip_ready = 1'b1;
        step(1);
        bus.req = 1'b0;
        chk("rv_no_done",       {7'd0, bus.done},       8'd0);
        chk("rv_rst_low",       {7'd0, bus.chip_rst_n}, 8'd0);
        chk("rv_busy",          {7'd0, bus.busy},       8'd1);
        chk("rv_count_same",    bus.rst_count,          8'd0);
        step(204);
        chk("rv_release",       {7'd0, bus.chip_rst_n}, 8'd1);
        step(1);
        chk("rv_done_after",    {7'd0, bus.done},       8'd1);
        chk("rv_count_1",       bus.rst_count,          8'd1);
    endtask

    task automatic test_back_to_back();
        apply_reset(1'b1);
        step(205);
        for (int i = 2; i <= 255; i++) begin
            run_seq();
        end
        chk("b2b_count_255",    bus.rst_count,          8'hFF);
        for (int i = 256; i <= 260; i++) begin
            run_seq();
        end
        chk("b2b_done_sat",     {7'd0, bus.done},       8'd1);
        chk("b2b_count_hold",   bus.rst_count,          8'hFF);
    endtask

    task automatic test_rst_mid_wait();
        apply_reset(1'b1);
        step(205);
        for (int i = 0; i < 4; i++) begin
            run_seq();
        end
        chk("rm_count_5",       bus.rst_count,          8'd5);
        bus.chip_ready = 1'b0;
        bus.req        = 1'b1;
        step(1);
        bus.req = 1'b0;
        step(210);
        chk("rm_in_wait_rel",   {7'd0, bus.chip_rst_n}, 8'd1);
        chk("rm_in_wait_busy",  {7'd0, bus.busy},       8'd1);
        rst = 1'b1;
        step(1);
        chk("rm_rst_low",       {7'd0, bus.chip_rst_n}, 8'd0);
        chk("rm_busy",          {7'd0, bus.busy},       8'd1);
        chk("rm_count_0",       bus.rst_count,          8'd0);
        chk("rm_timeout_0",     {7'd0, bus.timeout_err}, 8'd0);
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        n_pass         = 0;
        n_total        = 0;
        rst            = 1'b1;
        bus.req        = 1'b0;
        bus.chip_ready = 1'b0;
        test_reset();
        test_power_on();
        test_timeout();
        test_req_restart();
        test_req_vs_ready();
        test_back_to_back();
        test_rst_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
